sim_uart_mmio: RTL
==================

# sim_uart_mmio

Memory-mapped console responder for the simulation top. Decodes a small register window on the CPU's data-memory port (ce/raddr/rdata/waddr/wdata/wen, same protocol the RAM model answers) and bridges it to the simulator console ports.
- Stores go to a TX FIFO that drains onto io_uart_out_valid/io_uart_out_ch.
- Loads return console input polled through io_uart_in_valid/io_uart_in_ch.
- Instantiated alongside the RAM model in SimTop; its hit flag steers the read-data mux.

## Interface
Parameters:
- BASE_ADDR, 32'h1FE0_01E0, byte base of the 8-byte register window
- TX_DEPTH, 8, TX FIFO entries (power of two, >=2)
- RX_POLL, 16, cycles between console input polls while RX holding register is empty (>=1)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock, all state on posedge
- reset  in  1  synchronous active-high reset
- ce  in  1  port enable; reads and writes are ignored when low
- raddr  in  32  read byte address
- rdata  out  32  registered read data
- rhit  out  1  registered; high when rdata is from this block
- waddr  in  32  write byte address
- wdata  in  32  write data, bits [7:0] used for DATA
- wen  in  1  write strobe, qualified by ce
- io_uart_out_valid  out  1  console TX strobe, one char per cycle
- io_uart_out_ch  out  8  console TX character
- io_uart_in_valid  out  1  console input poll request
- io_uart_in_ch  in  8  console reply, same cycle as poll; 8'hFF = no char

## Operation
- Hit: addr[31:3] == BASE_ADDR[31:3]. Offset 0x0 = DATA, 0x4 = STATUS. Other low bits alias by addr[2].
- DATA write (ce & wen & hit): push wdata[7:0] into the TX FIFO.
  - FIFO full: character dropped, ovf_cnt increments, saturating at 15.
- DATA read (ce & read hit): rdata = {24'b0, rx_char} if rx_valid, else 32'h0000_00FF.
  - Read with rx_valid set clears rx_valid (pop).
- STATUS read fields:
  - bit0 rx_valid
  - bit1 tx_full
  - bit2 tx_empty
  - bits[7:4] ovf_cnt
  - bits[15:8] tx_count (zero-extended)
  - all other bits zero
  - STATUS reads have no side effects.
  - STATUS writes clear ovf_cnt; other write data is ignored.
- TX drain: every cycle the FIFO is non-empty, pop the head and present it on io_uart_out_ch with io_uart_out_valid=1.
  - Push and pop in the same cycle are allowed.
  - Push into a full FIFO is still dropped, even when a pop occurs that cycle.
- RX poll counter counts only while rx_valid=0. When it reaches RX_POLL-1:
  - io_uart_in_valid=1 for one cycle and the counter wraps to 0.
  - If io_uart_in_ch != 8'hFF that cycle, latch it into rx_char and set rx_valid.
- Pop vs capture in the same cycle: pop wins. A capture is only possible while rx_valid=0, so no character is lost.
- Non-hit accesses: rhit=0, rdata=0. No state change.

## Timing
- Read latency 1: rdata/rhit update on the edge after the ce/raddr cycle. The pop takes effect on that same edge.
- Write-to-console latency: a char written at edge N appears on io_uart_out_valid in cycle N+1 if the FIFO was empty.
- TX throughput: 1 char/cycle.
- STATUS read in the cycle immediately after a write reflects that write.
- Values on reset (reset asserted at any time, including mid-drain or mid-poll):
  - FIFO emptied, pointers 0
  - rx_valid=0, rx_char=0, ovf_cnt=0, poll counter=0
  - rdata=0, rhit=0
  - io_uart_out_valid=0, io_uart_out_ch=0, io_uart_in_valid=0

## Configuration
- SIM_UART_RX_EN defined: RX poll path, rx_char/rx_valid and the DATA-read pop are built as described.
- SIM_UART_RX_EN undefined:
  - io_uart_in_valid tied 0 and io_uart_in_ch ignored.
  - DATA read always returns 32'h0000_00FF.
  - STATUS bit0 always 0.
  - TX path unchanged.

## Structure
- Shared package sim_uart_pkg:
  - UART_DATA_OFS = 3'h0, UART_STAT_OFS = 3'h4
  - STATUS bit-position constants
  - UART_NO_CHAR = 8'hFF
  - default BASE_ADDR
- One sub-module: uart_tx_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by depth.
  - Pointers are one bit wider than log2(TX_DEPTH) for the full/empty distinction.

## Test plan
- Reset mid-drain: write 'A','B','C' to DATA, assert reset one cycle after the first char is out. Required: no further out_valid, STATUS reads 32'h0000_0004.
- Write "Hi" (0x48, 0x69) on consecutive cycles. Required: out_valid high for 2 consecutive cycles, ch 0x48 then 0x69; STATUS bit2 returns to 1.
- Hold out drain by writing 10 chars back-to-back with TX_DEPTH=8 and forcing push/pop overlap off (bench stalls drain via full-only scenario). Required: exactly the dropped count appears in STATUS[7:4]; a STATUS write then reads ovf_cnt=0.
- RX poll: io_uart_in_ch=8'hFF for 3 polls, then 0x41. Required: io_uart_in_valid pulses every 16 cycles, and STATUS bit0 rises the edge after the 4th poll.
- RX read: DATA read after capture returns 32'h41, and the next DATA read returns 32'hFF. With a read pop and a poll in the same cycle, the next poll picks up the new char.
- Non-hit address 0x1C00_0000 read/write: rhit=0, rdata=0, no out_valid; SIM_UART_RX_EN undefined build: in_valid never asserts, DATA reads 32'hFF.

Source files
------------

// File: rtl/sim_uart_pkg.sv
// Shared constants for the simulation console responder: register offsets,
// STATUS bit positions, the "no character" code and the default window base.
package sim_uart_pkg;

  localparam logic [2:0]  UART_DATA_OFS      = 3'h0;
  localparam logic [2:0]  UART_STAT_OFS      = 3'h4;

  localparam int          STAT_RXV_BIT       = 0;
  localparam int          STAT_TXFULL_BIT    = 1;
  localparam int          STAT_TXEMPTY_BIT   = 2;
  localparam int          STAT_OVF_LSB       = 4;
  localparam int          STAT_TXCNT_LSB     = 8;

  localparam logic [7:0]  UART_NO_CHAR       = 8'hFF;
  localparam logic [31:0] UART_BASE_ADDR_DEF = 32'h1FE0_01E0;

  typedef enum logic {
    UART_REG_DATA = 1'b0,
    UART_REG_STAT = 1'b1
  } uart_reg_e;

  // Low address bits select the register; only bit 2 matters, the rest alias.
  function automatic uart_reg_e uart_decode(input logic [2:0] ofs);
    return ((ofs & UART_STAT_OFS) == UART_STAT_OFS) ? UART_REG_STAT : UART_REG_DATA;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for console TX characters. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // A push into a full FIFO is refused even if a pop frees a slot this cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state pointer arithmetic.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop_ok)  rd_d = rd_q + PW'(1);
  end

  // Pointer registers; only control state is reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Character storage, written on accepted pushes.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sim_uart_mmio.sv
// Memory-mapped console responder: DATA/STATUS window on the CPU data port,
// TX FIFO draining to the simulator console, polled console input.
// Build option: define SIM_UART_RX_EN to include the RX poll path; without it
// DATA reads return 0xFF, STATUS bit0 is 0 and no polls are issued.
module sim_uart_mmio
  import sim_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = UART_BASE_ADDR_DEF,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_POLL   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  output logic        rhit,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wen,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'h1;
  endfunction

  logic          rd_hit, wr_hit;
  uart_reg_e     rd_sel, wr_sel;
  logic          tx_push, stat_wr, rx_pop;
  logic          tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic [3:0]    ovf_q, ovf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rhit_q;
  logic [31:0]   status;
  logic          rx_valid_w;
  logic [7:0]    rx_char_w;
  logic          unused_bits;

  assign rd_hit  = ce && (raddr[31:3] == BASE_ADDR[31:3]);
  assign wr_hit  = ce && wen && (waddr[31:3] == BASE_ADDR[31:3]);
  assign rd_sel  = uart_decode(raddr[2:0]);
  assign wr_sel  = uart_decode(waddr[2:0]);
  assign tx_push = wr_hit && (wr_sel == UART_REG_DATA);
  assign stat_wr = wr_hit && (wr_sel == UART_REG_STAT);
  assign rx_pop  = rd_hit && (rd_sel == UART_REG_DATA) && rx_valid_w;

  uart_tx_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (tx_push),
    .din_i   (wdata[7:0]),
    .pop_i   (~tx_empty),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // The FIFO head is on the console whenever anything is queued.
  assign io_uart_out_valid = ~tx_empty;
  assign io_uart_out_ch    = tx_empty ? 8'h00 : tx_head;

`ifdef SIM_UART_RX_EN
  localparam int PW = (RX_POLL > 1) ? $clog2(RX_POLL) : 1;

  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_char_q, rx_char_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          poll_now;

  assign poll_now         = ~rx_valid_q && (poll_q == PW'(RX_POLL - 1));
  assign io_uart_in_valid = poll_now;
  assign rx_valid_w       = rx_valid_q;
  assign rx_char_w        = rx_char_q;
  assign unused_bits      = ^wdata[31:8];

  // Holding register: pop on DATA read, otherwise poll while empty.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_char_d  = rx_char_q;
    poll_d     = poll_q;
    if (rx_pop) begin
      rx_valid_d = 1'b0;
    end else if (~rx_valid_q) begin
      if (poll_now) begin
        poll_d = '0;
        if (io_uart_in_ch != UART_NO_CHAR) begin
          rx_char_d  = io_uart_in_ch;
          rx_valid_d = 1'b1;
        end
      end else begin
        poll_d = poll_q + PW'(1);
      end
    end
  end

  // RX state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_char_q  <= 8'h00;
      poll_q     <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_char_q  <= rx_char_d;
      poll_q     <= poll_d;
    end
  end
`else
  assign io_uart_in_valid = 1'b0;
  assign rx_valid_w       = 1'b0;
  assign rx_char_w        = 8'h00;
  assign unused_bits      = ^{wdata[31:8], io_uart_in_ch, rx_pop};
`endif

  // STATUS word assembly.
  always_comb begin
    status                           = '0;
    status[STAT_RXV_BIT]             = rx_valid_w;
    status[STAT_TXFULL_BIT]          = tx_full;
    status[STAT_TXEMPTY_BIT]         = tx_empty;
    status[STAT_OVF_LSB +: 4]        = ovf_q;
    status[STAT_TXCNT_LSB +: 8]      = 8'(tx_count);
  end

  // Read mux and overflow counter next state.
  always_comb begin
    rdata_d = 32'h0;
    if (rd_hit) begin
      if (rd_sel == UART_REG_STAT) rdata_d = status;
      else if (rx_valid_w)         rdata_d = {24'h0, rx_char_w};
      else                         rdata_d = {24'h0, UART_NO_CHAR};
    end
    ovf_d = ovf_q;
    if (tx_push && tx_full) ovf_d = sat_inc4(ovf_q);
    if (stat_wr)            ovf_d = 4'h0;
  end

  // Read-port and overflow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= 32'h0;
      rhit_q  <= 1'b0;
      ovf_q   <= 4'h0;
    end else begin
      rdata_q <= rdata_d;
      rhit_q  <= rd_hit;
      ovf_q   <= ovf_d;
    end
  end

  assign rdata = rdata_q;
  assign rhit  = rhit_q;

endmodule
